// File: rtl/sysbus_decoder.sv
// sysbus_decoder: system-bus address decoder with one-hot slave enables, registered read-data mux,
// per-read timeout and error response/logging for unmapped accesses.
module sysbus_decoder #(
    parameter int N_SLV = 4,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SEL_HI = 31,
    parameter int SEL_LO = 28,
    parameter logic [N_SLV*(SEL_HI-SEL_LO+1)-1:0] SLV_BASE = 16'h3A90,
    parameter int TIMEOUT = 16,
    parameter logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_en,
    input  logic                m_rdwr,
    input  logic [AW-1:0]       m_addr,
    input  logic [DW-1:0]       m_wr_data,
    input  logic [DW/8-1:0]     m_mask,
    output logic                m_stall,
    output logic [DW-1:0]       m_rd_data,
    output logic                m_rd_valid,
    output logic                m_err,
    output logic [N_SLV-1:0]    s_en,
    output logic                s_rdwr,
    output logic [AW-1:0]       s_addr,
    output logic [DW-1:0]       s_wr_data,
    output logic [DW/8-1:0]     s_mask,
    input  logic [N_SLV*DW-1:0] s_rd_data,
    input  logic [N_SLV-1:0]    s_rd_valid,
    output logic [AW-1:0]       err_addr,
    output logic [7:0]          err_count
);
    localparam int SW = SEL_HI - SEL_LO + 1;
    localparam int SELW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          r_state;
    logic [SELW-1:0] r_sel;
    logic [AW-1:0]   r_addr;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_rd_data;
    logic            r_rd_valid;
    logic            r_err;
    logic [AW-1:0]   r_err_addr;
    logic [7:0]      r_err_count;

    state_t          w_nxt;
    logic [SELW-1:0] w_sel;
    logic            w_mapped;
    logic            w_req;
    logic            w_vld;
    logic            w_tout;
    logic            w_start;
    logic            w_rv;
    logic            w_err;
    logic            w_log;
    logic [AW-1:0]   w_log_addr;
    logic [DW-1:0]   w_data;

    // Scan downwards so the lowest matching slave index ends up selected
    always_comb begin
        w_sel = '0;
        w_mapped = 1'b0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (m_addr[SEL_HI:SEL_LO] == SLV_BASE[i*SW +: SW]) begin
                w_sel = SELW'(i);
                w_mapped = 1'b1;
            end
        end
    end

    assign w_req  = m_en & (r_state != WAIT);
    assign w_vld  = s_rd_valid[r_sel];
    assign w_tout = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_nxt = r_state;
        w_rv = 1'b0;
        w_err = 1'b0;
        w_log = 1'b0;
        w_log_addr = m_addr;
        w_start = 1'b0;
        w_data = r_rd_data;
        if (r_state == WAIT) begin
            if (w_vld) begin
                w_nxt = RESP;
                w_rv = 1'b1;
                w_data = s_rd_data[r_sel*DW +: DW];
            end else if (w_tout) begin
                w_nxt = RESP;
                w_rv = 1'b1;
                w_err = 1'b1;
                w_data = ERR_DATA;
                w_log = 1'b1;
                w_log_addr = r_addr;
            end
        end else begin
            w_nxt = IDLE;
            if (w_req && w_mapped && !m_rdwr) begin
                w_nxt = WAIT;
                w_start = 1'b1;
            end else if (w_req && !w_mapped) begin
                w_err = 1'b1;
                w_log = 1'b1;
                w_nxt = m_rdwr ? IDLE : RESP;
                w_rv = !m_rdwr;
                w_data = m_rdwr ? r_rd_data : ERR_DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel <= '0;
            r_addr <= '0;
            r_cnt <= '0;
            r_rd_data <= '0;
            r_rd_valid <= 1'b0;
            r_err <= 1'b0;
            r_err_addr <= '0;
            r_err_count <= '0;
        end else begin
            r_state <= w_nxt;
            r_rd_valid <= w_rv;
            r_err <= w_err;
            r_rd_data <= w_data;
            if (w_start) begin
                r_sel <= w_sel;
                r_addr <= m_addr;
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_log) begin
                r_err_addr <= w_log_addr;
                if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    // Gate with rst so no slave sees an enable while the decoder is held in reset
    assign s_en = (w_req && w_mapped && !rst) ? (N_SLV'(1) << w_sel) : '0;
    assign m_stall = (r_state == WAIT);
    assign m_rd_data = r_rd_data;
    assign m_rd_valid = r_rd_valid;
    assign m_err = r_err;
    assign s_rdwr = m_rdwr;
    assign s_addr = {m_addr[AW-1:2], 2'b00};
    assign s_wr_data = m_wr_data;
    assign s_mask = m_mask;
    assign err_addr = r_err_addr;
    assign err_count = r_err_count;
endmodule
